// File: rtl/apb_nslave_master_pkg.sv
// apb_pkg: shared types and helpers for the APB N-slave master.
//   apb_state_e : master FSM state encoding
//   sel_width() : number of upper address bits used to pick a slave
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } apb_state_e;

  // At least one select bit, even for a single attached slave.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_nslave_master_addr_decoder.sv
// apb_addr_decoder: combinational slave decode from the command address.
//   cmd_addr : command address; the top sel_width(NUM_SLV) bits are the index
//   sel      : one-hot slave select, all-zero on a decode error
//   dec_err  : index does not map to an attached slave
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int NUM_SLV = 2
) (
  input  logic [ADDR_W-1:0]  cmd_addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               dec_err
);

  localparam int SEL_W = sel_width(NUM_SLV);

  logic [SEL_W-1:0] idx;
  logic             unused_addr;

  assign idx         = cmd_addr[ADDR_W-1 -: SEL_W];
  // Only the top bits select a slave; the rest are address payload.
  assign unused_addr = ^cmd_addr;

  always_comb begin
    sel     = '0;
    dec_err = (int'(idx) >= NUM_SLV);
    for (int i = 0; i < NUM_SLV; i++) begin
      if (int'(idx) == i) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_nslave_master.sv
// apb_nslave_master: single-command APB master driving NUM_SLV slaves.
//   PCLK/PRESET          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (cmd_write, cmd_addr, cmd_wdata)
//   rsp_valid            : one-cycle completion pulse with rsp_rdata/rsp_err
//   PADDR..PSEL          : APB request side, PSEL one-hot or zero
//   PRDATA/PREADY/PSLVERR: per-slave APB responses, slave i at slice i
// Optional: define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC
// cycles without PREADY (error response).
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL asserted, PENABLE low (one cycle)
// ACCESS | PSEL and PENABLE high, waiting for PREADY of the selected slave
// DECERR | address maps to no slave; one cycle, then error response
module apb_nslave_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int NUM_SLV     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  apb_state_e          state_q, state_d;
  logic [NUM_SLV-1:0]  sel_q;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_err;
  logic                sel_ready, sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                done, done_err;
  logic [DATA_W-1:0]   done_rdata;
  logic                accept;

  apb_addr_decoder #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) u_dec (
    .cmd_addr (cmd_addr),
    .sel      (dec_sel),
    .dec_err  (dec_err)
  );

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign PSEL      = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
  assign PENABLE   = (state_q == ACCESS);

  // Responses are taken only from the registered one-hot selection, so
  // unselected slaves never influence the transfer.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_hit;

  // The cycle that would bring the count to TIMEOUT_CYC ends the transfer.
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !sel_ready) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  logic to_hit;
  logic unused_timeout;
  assign to_hit         = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_d    = state_q;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = dec_err ? DECERR : SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d    = IDLE;
          done       = 1'b1;
          done_err   = sel_err;
          done_rdata = PWRITE ? '0 : sel_rdata;
        end else if (to_hit) begin
          state_d  = IDLE;
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      DECERR: begin
        state_d  = IDLE;
        done     = 1'b1;
        done_err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= done;
      if (accept) begin
        sel_q  <= dec_sel;
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
      end
      if (done) begin
        rsp_rdata <= done_rdata;
        rsp_err   <= done_err;
      end
    end
  end

endmodule

// File: tb/tb_apb_nslave_master.sv
module tb_apb_nslave_master;

  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 8;
  localparam int NUM_SLV     = 3;
  localparam int TIMEOUT_CYC = 4;
  localparam int TB_SEL_W    = $clog2(NUM_SLV);

  logic                      PCLK;
  logic                      PRESET = 1'b1;
  logic                      cmd_valid = 1'b0;
  logic                      cmd_ready;
  logic                      cmd_write = 1'b0;
  logic [ADDR_W-1:0]         cmd_addr = '0;
  logic [DATA_W-1:0]         cmd_wdata = '0;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [ADDR_W-1:0]         PADDR;
  logic                      PWRITE;
  logic [DATA_W-1:0]         PWDATA;
  logic                      PENABLE;
  logic [NUM_SLV-1:0]        PSEL;
  logic [NUM_SLV*DATA_W-1:0] PRDATA = '0;
  logic [NUM_SLV-1:0]        PREADY = '0;
  logic [NUM_SLV-1:0]        PSLVERR = '0;

  int vec = 0;
  int err = 0;

  // Per-slave behaviour: number of not-ready ACCESS cycles, read data, error.
  int                wait_cyc [NUM_SLV];
  logic [DATA_W-1:0] slv_data [NUM_SLV];
  logic              slv_err  [NUM_SLV];
  int                acc_cnt  [NUM_SLV];

  logic [DATA_W-1:0] last_rdata = '0;
  logic              last_err = 1'b0;

  apb_nslave_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave models: a selected slave in ACCESS answers after its wait count;
  // everything else drives random noise that the master must ignore.
  always @(negedge PCLK) begin
    for (int i = 0; i < NUM_SLV; i++) begin
      if (PSEL[i] && PENABLE) begin
        acc_cnt[i] = acc_cnt[i] + 1;
        PREADY[i]  = (acc_cnt[i] > wait_cyc[i]);
        PRDATA[i*DATA_W +: DATA_W] = slv_data[i];
        PSLVERR[i] = slv_err[i];
      end else begin
        acc_cnt[i] = 0;
        PREADY[i]  = 1'($urandom);
        PRDATA[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        PSLVERR[i] = 1'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(negedge PCLK);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("hold_rdata", 32'(rsp_rdata), 32'(last_rdata));
      chk("hold_err", 32'(rsp_err), 32'(last_err));
    end
  endtask

  // Issues one command at the current negedge and follows it to its response.
  // Returns at the negedge where rsp_valid is seen, so a following call
  // issues the next command in the response cycle.
  task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input int waits,
                         input logic [DATA_W-1:0] sd, input logic se);
    int idx, exp_lat, exp_psel_cyc, exp_pen_cyc, n, psel_cyc, pen_cyc;
    bit dec, tout, got;
    logic [NUM_SLV-1:0] exp_psel;
    logic               exp_err;
    logic [DATA_W-1:0]  exp_rd;

    idx  = int'(addr) / (1 << (ADDR_W - TB_SEL_W));
    dec  = (idx >= NUM_SLV);
`ifdef APB_MASTER_TIMEOUT_EN
    tout = !dec && (waits >= TIMEOUT_CYC);
`else
    tout = 1'b0;
`endif
    if (dec) begin
      exp_lat = 2; exp_psel_cyc = 0; exp_pen_cyc = 0; exp_psel = '0;
    end else if (tout) begin
      exp_lat = 2 + TIMEOUT_CYC; exp_psel_cyc = 1 + TIMEOUT_CYC;
      exp_pen_cyc = TIMEOUT_CYC; exp_psel = NUM_SLV'(1 << idx);
    end else begin
      exp_lat = 3 + waits; exp_psel_cyc = 2 + waits;
      exp_pen_cyc = 1 + waits; exp_psel = NUM_SLV'(1 << idx);
    end
    exp_err = dec || tout || se;
    exp_rd  = (dec || tout || wr) ? '0 : sd;

    if (!dec) begin
      wait_cyc[idx] = waits;
      slv_data[idx] = sd;
      slv_err[idx]  = se;
    end

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    chk("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = ADDR_W'($urandom);
    cmd_wdata = DATA_W'($urandom);
    cmd_write = 1'($urandom);

    n = 0; psel_cyc = 0; pen_cyc = 0; got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge PCLK);
      n++;
      if (PSEL != '0) begin
        psel_cyc++;
        chk("psel_onehot", 32'(PSEL), 32'(exp_psel));
        chk("paddr", 32'(PADDR), 32'(addr));
        chk("pwrite", 32'(PWRITE), 32'(wr));
        chk("pwdata", 32'(PWDATA), 32'(wd));
      end
      if (PENABLE) pen_cyc++;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("latency", 32'(n), 32'(exp_lat));
    chk("psel_cycles", 32'(psel_cyc), 32'(exp_psel_cyc));
    chk("penable_cycles", 32'(pen_cyc), 32'(exp_pen_cyc));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    chk("cmd_ready_on_rsp", 32'(cmd_ready), 32'd1);
    last_rdata = exp_rd;
    last_err   = exp_err;
  endtask

  task automatic start_stuck();
    wait_cyc[0] = 100000;
    slv_data[0] = 8'h77;
    slv_err[0]  = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h010; cmd_wdata = 8'h00;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_psel"}, 32'(PSEL), 32'd0);
    chk({tag, "_penable"}, 32'(PENABLE), 32'd0);
    chk({tag, "_pwrite"}, 32'(PWRITE), 32'd0);
    chk({tag, "_paddr"}, 32'(PADDR), 32'd0);
    chk({tag, "_pwdata"}, 32'(PWDATA), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pen_cnt, rsp_cnt;
    for (int i = 0; i < NUM_SLV; i++) begin
      wait_cyc[i] = 0; slv_data[i] = '0; slv_err[i] = 1'b0; acc_cnt[i] = 0;
    end

    // Reset state
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_all_zero("reset");
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    PRESET = 1'b0;
    idle(2);

    // Write to slave 1, zero wait states
    run_txn(1'b1, 9'h085, 8'hA5, 0, 8'h11, 1'b0);
    idle(1);
    // Read from slave 0 with three wait states
    run_txn(1'b0, 9'h005, 8'h00, 3, 8'h3C, 1'b0);
    idle(2);
    // Index 3 with three slaves: decode error
    run_txn(1'b0, 9'h1C0, 8'h00, 0, 8'h00, 1'b0);
    idle(1);
    // Slave error on a read, then back-to-back commands in the response cycle
    run_txn(1'b0, 9'h123, 8'h00, 0, 8'h5A, 1'b1);
    run_txn(1'b1, 9'h0F0, 8'hC3, 1, 8'h99, 1'b1);
    run_txn(1'b0, 9'h1FF, 8'h00, 0, 8'h00, 1'b0);
    run_txn(1'b0, 9'h07E, 8'h00, 2, 8'hE1, 1'b0);
    idle(1);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
              int'($urandom_range(0, 3)), DATA_W'($urandom),
              ($urandom_range(0, 3) == 0));
      idle(int'($urandom_range(0, 2)));
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Slave never ready: aborted after TIMEOUT_CYC ACCESS cycles
    run_txn(1'b0, 9'h010, 8'h00, 1000, 8'h77, 1'b0);
    idle(1);
    start_stuck();
    @(negedge PCLK);
    @(negedge PCLK);
    chk("stuck_in_access", 32'(PENABLE), 32'd1);
`else
    // Slave never ready: the master keeps waiting
    start_stuck();
    @(negedge PCLK);
    pen_cnt = 0; rsp_cnt = 0;
    repeat (100) begin
      @(negedge PCLK);
      if (PENABLE) pen_cnt++;
      if (rsp_valid) rsp_cnt++;
    end
    chk("stuck_penable_cycles", 32'(pen_cnt), 32'd100);
    chk("stuck_no_rsp", 32'(rsp_cnt), 32'd0);
`endif

    // Reset during ACCESS aborts silently
    PRESET = 1'b1;
    @(negedge PCLK);
    check_all_zero("midreset");
    PRESET = 1'b0;
    wait_cyc[0] = 0;
    @(negedge PCLK);
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
    last_rdata = '0;
    last_err   = 1'b0;
    idle(4);

    // Normal operation after reset
    run_txn(1'b0, 9'h042, 8'h00, 1, 8'h6B, 1'b0);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
